// File: rtl/w0rm_alu_pkg.sv
// Definitions shared by the W0RM ALU units and their writeback collector:
// flag bit positions, opcode encodings and a flag packing helper.
package w0rm_alu_pkg;

  localparam int ALU_FLAG_WIDTH = 4;
  localparam int ALU_FLAG_ZERO  = 0;
  localparam int ALU_FLAG_NEG   = 1;
  localparam int ALU_FLAG_OVER  = 2;
  localparam int ALU_FLAG_CARRY = 3;

  typedef enum logic [3:0] {
    ALU_OP_AND = 4'h0,
    ALU_OP_OR  = 4'h1,
    ALU_OP_XOR = 4'h2,
    ALU_OP_NOT = 4'h3,
    ALU_OP_ADD = 4'h4,
    ALU_OP_SUB = 4'h5,
    ALU_OP_ADC = 4'h6,
    ALU_OP_SBC = 4'h7,
    ALU_OP_SHL = 4'h8,
    ALU_OP_SHR = 4'h9,
    ALU_OP_ASR = 4'hA,
    ALU_OP_ROL = 4'hB
  } alu_op_e;

  function automatic logic [ALU_FLAG_WIDTH-1:0] alu_pack_flags(
    input logic z, input logic n, input logic v, input logic c);
    logic [ALU_FLAG_WIDTH-1:0] f;
    f = '0;
    f[ALU_FLAG_ZERO]  = z;
    f[ALU_FLAG_NEG]   = n;
    f[ALU_FLAG_OVER]  = v;
    f[ALU_FLAG_CARRY] = c;
    return f;
  endfunction

endpackage

// File: rtl/w0rm_alu_writeback_if.sv
// Issue channel and register-file write channel of the ALU writeback block.
// master = issue stage / register file side, slave = writeback collector.
interface w0rm_alu_writeback_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int UNIT_SEL_WIDTH = 2
);
  logic                      issue_valid;
  logic                      issue_ready;
  logic [UNIT_SEL_WIDTH-1:0] issue_unit;
  logic [REG_ADDR_WIDTH-1:0] issue_dest;
  logic                      issue_set_flags;

  logic                      wb_valid;
  logic                      wb_ready;
  logic [REG_ADDR_WIDTH-1:0] wb_reg;
  logic [DATA_WIDTH-1:0]     wb_data;

  modport master (
    output issue_valid, issue_unit, issue_dest, issue_set_flags, wb_ready,
    input  issue_ready, wb_valid, wb_reg, wb_data
  );

  modport slave (
    input  issue_valid, issue_unit, issue_dest, issue_set_flags, wb_ready,
    output issue_ready, wb_valid, wb_reg, wb_data
  );
endinterface

// File: rtl/w0rm_alu_wb_queue.sv
// In-order entry storage for the writeback collector: issue, completion and
// head pointers, each one bit wider than the index so full and empty differ.
module w0rm_alu_wb_queue
  import w0rm_alu_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int QUEUE_DEPTH    = 4,
  parameter int UNIT_SEL_WIDTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [UNIT_SEL_WIDTH-1:0] push_unit,
  input  logic [REG_ADDR_WIDTH-1:0] push_dest,
  input  logic                      push_set_flags,
  output logic                      push_ready,
  input  logic                      cmp_en,
  input  logic [DATA_WIDTH-1:0]     cmp_data,
  input  logic [ALU_FLAG_WIDTH-1:0] cmp_flags,
  output logic                      cmp_pending,
  output logic [UNIT_SEL_WIDTH-1:0] cmp_unit,
  input  logic                      pop,
  output logic                      head_valid,
  output logic [REG_ADDR_WIDTH-1:0] head_dest,
  output logic [DATA_WIDTH-1:0]     head_data,
  output logic [ALU_FLAG_WIDTH-1:0] head_flags,
  output logic                      head_set_flags,
  output logic                      busy
);
  localparam int IDX_W = $clog2(QUEUE_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] FULL_COUNT = PTR_W'(QUEUE_DEPTH);

  logic [PTR_W-1:0]          wr_ptr, cmp_ptr, rd_ptr;
  logic [IDX_W-1:0]          wr_idx, cmp_idx, rd_idx;
  logic [UNIT_SEL_WIDTH-1:0] unit_q      [QUEUE_DEPTH];
  logic [REG_ADDR_WIDTH-1:0] dest_q      [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0]     data_q      [QUEUE_DEPTH];
  logic [ALU_FLAG_WIDTH-1:0] flags_q     [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0]    set_flags_q;
  logic [QUEUE_DEPTH-1:0]    done_q;

  assign wr_idx  = wr_ptr[IDX_W-1:0];
  assign cmp_idx = cmp_ptr[IDX_W-1:0];
  assign rd_idx  = rd_ptr[IDX_W-1:0];

  assign push_ready     = (wr_ptr - rd_ptr) != FULL_COUNT;
  assign cmp_pending    = cmp_ptr != wr_ptr;
  assign cmp_unit       = unit_q[cmp_idx];
  assign head_valid     = done_q[rd_idx] && (rd_ptr != cmp_ptr);
  assign head_dest      = dest_q[rd_idx];
  assign head_data      = data_q[rd_idx];
  assign head_flags     = flags_q[rd_idx];
  assign head_set_flags = set_flags_q[rd_idx];
  assign busy           = wr_ptr != rd_ptr;

  // Push, completion and pop always land on distinct entries, so the three
  // updates can share one process without ordering concerns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      cmp_ptr     <= '0;
      rd_ptr      <= '0;
      done_q      <= '0;
      set_flags_q <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        unit_q[i]  <= '0;
        dest_q[i]  <= '0;
        data_q[i]  <= '0;
        flags_q[i] <= '0;
      end
    end else begin
      if (push) begin
        unit_q[wr_idx]      <= push_unit;
        dest_q[wr_idx]      <= push_dest;
        set_flags_q[wr_idx] <= push_set_flags;
        done_q[wr_idx]      <= 1'b0;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (cmp_en) begin
        data_q[cmp_idx]  <= cmp_data;
        flags_q[cmp_idx] <= cmp_flags;
        done_q[cmp_idx]  <= 1'b1;
        cmp_ptr          <= cmp_ptr + 1'b1;
      end
      if (pop) begin
        done_q[rd_idx] <= 1'b0;
        rd_ptr         <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/w0rm_alu_writeback.sv
// ALU writeback collector: matches unit completion pulses to issued ops in
// order, retires them to the register file and owns the Z/N/V/C flags.
module w0rm_alu_writeback
  import w0rm_alu_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int NUM_UNITS       = 4,
  parameter int REG_ADDR_WIDTH  = 4,
  parameter int QUEUE_DEPTH     = 4,
  localparam int UNIT_SEL_WIDTH = $clog2(NUM_UNITS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  w0rm_alu_writeback_if.slave             bus,
  input  logic [NUM_UNITS-1:0]            unit_result_valid,
  input  logic [NUM_UNITS*DATA_WIDTH-1:0] unit_result,
  input  logic [NUM_UNITS*ALU_FLAG_WIDTH-1:0] unit_result_flags,
  output logic [ALU_FLAG_WIDTH-1:0]       flags,
  output logic                            busy,
  output logic                            seq_error
);
  logic                      push, pop;
  logic                      cmp_pending, pulse_any, pulse_legal;
  logic [UNIT_SEL_WIDTH-1:0] cmp_unit, pulse_unit;
  logic [DATA_WIDTH-1:0]     pulse_data;
  logic [ALU_FLAG_WIDTH-1:0] pulse_flags, head_flags;
  logic                      head_set_flags;

  always_comb begin
    pulse_unit = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (unit_result_valid[u]) pulse_unit = UNIT_SEL_WIDTH'(u);
    end
  end

  // Only a single pulse from the unit owning the oldest pending op is accepted.
  assign pulse_any   = |unit_result_valid;
  assign pulse_legal = $onehot(unit_result_valid) && cmp_pending && (cmp_unit == pulse_unit);
  assign pulse_data  = unit_result[int'(pulse_unit)*DATA_WIDTH +: DATA_WIDTH];
  assign pulse_flags = unit_result_flags[int'(pulse_unit)*ALU_FLAG_WIDTH +: ALU_FLAG_WIDTH];

  assign push = bus.issue_valid && bus.issue_ready;
  assign pop  = bus.wb_valid && bus.wb_ready;

  w0rm_alu_wb_queue #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
    .QUEUE_DEPTH    (QUEUE_DEPTH),
    .UNIT_SEL_WIDTH (UNIT_SEL_WIDTH)
  ) u_queue (
    .clk            (clk),
    .rst_n          (rst_n),
    .push           (push),
    .push_unit      (bus.issue_unit),
    .push_dest      (bus.issue_dest),
    .push_set_flags (bus.issue_set_flags),
    .push_ready     (bus.issue_ready),
    .cmp_en         (pulse_legal),
    .cmp_data       (pulse_data),
    .cmp_flags      (pulse_flags),
    .cmp_pending    (cmp_pending),
    .cmp_unit       (cmp_unit),
    .pop            (pop),
    .head_valid     (bus.wb_valid),
    .head_dest      (bus.wb_reg),
    .head_data      (bus.wb_data),
    .head_flags     (head_flags),
    .head_set_flags (head_set_flags),
    .busy           (busy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags     <= '0;
      seq_error <= 1'b0;
    end else begin
      if (pop && head_set_flags) flags <= head_flags;
      if (pulse_any && !pulse_legal) seq_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_w0rm_alu_writeback.sv
// Self-checking bench for w0rm_alu_writeback: directed vector table, hand
// sequences for errors/wrap/reset, then random traffic against an op-list model.
module tb_w0rm_alu_writeback;
  import w0rm_alu_pkg::*;

  localparam int DW = 8;
  localparam int NU = 4;
  localparam int RW = 4;
  localparam int QD = 4;
  localparam int UW = 2;

  logic          clk;
  logic          rst_n;
  logic [NU-1:0] unit_result_valid;
  logic [NU*DW-1:0] unit_result;
  logic [NU*4-1:0]  unit_result_flags;
  logic [3:0]    flags;
  logic          busy;
  logic          seq_error;

  int compared;
  int mismatched;

  w0rm_alu_writeback_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW), .UNIT_SEL_WIDTH(UW)) bus ();

  w0rm_alu_writeback #(
    .DATA_WIDTH     (DW),
    .NUM_UNITS      (NU),
    .REG_ADDR_WIDTH (RW),
    .QUEUE_DEPTH    (QD)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .bus               (bus),
    .unit_result_valid (unit_result_valid),
    .unit_result       (unit_result),
    .unit_result_flags (unit_result_flags),
    .flags             (flags),
    .busy              (busy),
    .seq_error         (seq_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the in-flight ops as a plain list in issue order.
  typedef struct packed {
    logic [UW-1:0] unit;
    logic [RW-1:0] dest;
    logic          sf;
    logic          done;
    logic [DW-1:0] data;
    logic [3:0]    fl;
  } op_t;

  op_t        m_q[$];
  logic [3:0] m_flags;
  logic       m_err;

  typedef struct packed {
    logic          iv;
    logic [UW-1:0] iu;
    logic [RW-1:0] idst;
    logic          isf;
    logic [NU-1:0] rm;
    logic [DW-1:0] rd;
    logic [3:0]    rf;
    logic          wbr;
    logic          e_ir;
    logic          e_wv;
    logic [RW-1:0] e_reg;
    logic [DW-1:0] e_data;
    logic [3:0]    e_flags;
    logic          e_busy;
  } vec_t;

  vec_t vecs[14];

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_flags = '0;
    m_err   = 1'b0;
  endtask

  function automatic int first_pending();
    for (int i = 0; i < m_q.size(); i++) begin
      if (!m_q[i].done) return i;
    end
    return -1;
  endfunction

  task automatic model_update();
    int   k;
    int   ui;
    logic ready;
    logic retire;
    op_t  e;
    ready  = (m_q.size() != QD);
    retire = (m_q.size() > 0) && m_q[0].done && bus.wb_ready;
    k      = first_pending();
    if (unit_result_valid != '0) begin
      ui = 0;
      for (int u = NU - 1; u >= 0; u--) if (unit_result_valid[u]) ui = u;
      if ($countones(unit_result_valid) == 1 && k >= 0 && int'(m_q[k].unit) == ui) begin
        e      = m_q[k];
        e.done = 1'b1;
        e.data = unit_result[ui*DW +: DW];
        e.fl   = unit_result_flags[ui*4 +: 4];
        m_q[k] = e;
      end else begin
        m_err = 1'b1;
      end
    end
    if (retire) begin
      if (m_q[0].sf) m_flags = m_q[0].fl;
      void'(m_q.pop_front());
    end
    if (bus.issue_valid && ready) begin
      e      = '0;
      e.unit = bus.issue_unit;
      e.dest = bus.issue_dest;
      e.sf   = bus.issue_set_flags;
      m_q.push_back(e);
    end
  endtask

  task automatic check_model();
    logic exp_wv;
    exp_wv = (m_q.size() > 0) && m_q[0].done;
    check_output("issue_ready", 32'(bus.issue_ready), 32'(m_q.size() != QD));
    check_output("busy", 32'(busy), 32'(m_q.size() != 0));
    check_output("wb_valid", 32'(bus.wb_valid), 32'(exp_wv));
    check_output("flags", 32'(flags), 32'(m_flags));
    check_output("seq_error", 32'(seq_error), 32'(m_err));
    if (exp_wv) begin
      check_output("wb_reg", 32'(bus.wb_reg), 32'(m_q[0].dest));
      check_output("wb_data", 32'(bus.wb_data), 32'(m_q[0].data));
    end
  endtask

  // Drives one cycle's inputs just after a rising edge and waits to the falling edge.
  task automatic apply_stimulus(input logic iv, input logic [UW-1:0] iu, input logic [RW-1:0] idst,
                                input logic isf, input logic [NU-1:0] rm, input logic [DW-1:0] rd,
                                input logic [3:0] rf, input logic wbr);
    bus.issue_valid     = iv;
    bus.issue_unit      = iu;
    bus.issue_dest      = idst;
    bus.issue_set_flags = isf;
    bus.wb_ready        = wbr;
    unit_result_valid   = rm;
    for (int u = 0; u < NU; u++) begin
      unit_result[u*DW +: DW]      = rm[u] ? rd : DW'($urandom);
      unit_result_flags[u*4 +: 4]  = rm[u] ? rf : 4'($urandom);
    end
    #4;
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic step(input logic iv, input logic [UW-1:0] iu, input logic [RW-1:0] idst,
                      input logic isf, input logic [NU-1:0] rm, input logic [DW-1:0] rd,
                      input logic [3:0] rf, input logic wbr);
    apply_stimulus(iv, iu, idst, isf, rm, rd, rf, wbr);
    check_model();
    advance();
  endtask

  task automatic idle(input logic wbr);
    step(1'b0, '0, '0, 1'b0, '0, '0, '0, wbr);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    model_reset();

    // Single op, then backpressure to full and drain with a flag-setting tail op.
    vecs[0]  = '{1'b1, 2'd0, 4'd3, 1'b1, 4'b0000, 8'h00, 4'h0, 1'b1, 1'b1, 1'b0, 4'd0, 8'h00, 4'b0000, 1'b0};
    vecs[1]  = '{1'b0, 2'd0, 4'd0, 1'b0, 4'b0001, 8'h00, 4'h1, 1'b1, 1'b1, 1'b0, 4'd0, 8'h00, 4'b0000, 1'b1};
    vecs[2]  = '{1'b0, 2'd0, 4'd0, 1'b0, 4'b0000, 8'h00, 4'h0, 1'b1, 1'b1, 1'b1, 4'd3, 8'h00, 4'b0000, 1'b1};
    vecs[3]  = '{1'b0, 2'd0, 4'd0, 1'b0, 4'b0000, 8'h00, 4'h0, 1'b0, 1'b1, 1'b0, 4'd0, 8'h00, 4'b0001, 1'b0};
    vecs[4]  = '{1'b1, 2'd0, 4'd1, 1'b0, 4'b0000, 8'h00, 4'h0, 1'b0, 1'b1, 1'b0, 4'd0, 8'h00, 4'b0001, 1'b0};
    vecs[5]  = '{1'b1, 2'd0, 4'd2, 1'b0, 4'b0001, 8'h11, 4'h6, 1'b0, 1'b1, 1'b0, 4'd0, 8'h00, 4'b0001, 1'b1};
    vecs[6]  = '{1'b1, 2'd0, 4'd3, 1'b0, 4'b0001, 8'h22, 4'h6, 1'b0, 1'b1, 1'b1, 4'd1, 8'h11, 4'b0001, 1'b1};
    vecs[7]  = '{1'b1, 2'd0, 4'd4, 1'b1, 4'b0001, 8'h33, 4'h6, 1'b0, 1'b1, 1'b1, 4'd1, 8'h11, 4'b0001, 1'b1};
    vecs[8]  = '{1'b1, 2'd0, 4'd9, 1'b0, 4'b0001, 8'h44, 4'hA, 1'b0, 1'b0, 1'b1, 4'd1, 8'h11, 4'b0001, 1'b1};
    vecs[9]  = '{1'b0, 2'd0, 4'd0, 1'b0, 4'b0000, 8'h00, 4'h0, 1'b1, 1'b0, 1'b1, 4'd1, 8'h11, 4'b0001, 1'b1};
    vecs[10] = '{1'b0, 2'd0, 4'd0, 1'b0, 4'b0000, 8'h00, 4'h0, 1'b1, 1'b1, 1'b1, 4'd2, 8'h22, 4'b0001, 1'b1};
    vecs[11] = '{1'b0, 2'd0, 4'd0, 1'b0, 4'b0000, 8'h00, 4'h0, 1'b1, 1'b1, 1'b1, 4'd3, 8'h33, 4'b0001, 1'b1};
    vecs[12] = '{1'b0, 2'd0, 4'd0, 1'b0, 4'b0000, 8'h00, 4'h0, 1'b1, 1'b1, 1'b1, 4'd4, 8'h44, 4'b0001, 1'b1};
    vecs[13] = '{1'b0, 2'd0, 4'd0, 1'b0, 4'b0000, 8'h00, 4'h0, 1'b0, 1'b1, 1'b0, 4'd0, 8'h00, 4'b1010, 1'b0};

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'($urandom), UW'($urandom), RW'($urandom), 1'($urandom),
                     NU'($urandom), DW'($urandom), 4'($urandom), 1'($urandom));
      @(posedge clk);
      #1;
    end
    check_output("reset issue_ready", 32'(bus.issue_ready), 32'd1);
    check_output("reset wb_valid", 32'(bus.wb_valid), 32'd0);
    check_output("reset wb_reg", 32'(bus.wb_reg), 32'd0);
    check_output("reset wb_data", 32'(bus.wb_data), 32'd0);
    check_output("reset flags", 32'(flags), 32'd0);
    check_output("reset busy", 32'(busy), 32'd0);
    check_output("reset seq_error", 32'(seq_error), 32'd0);
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      apply_stimulus(vecs[i].iv, vecs[i].iu, vecs[i].idst, vecs[i].isf,
                     vecs[i].rm, vecs[i].rd, vecs[i].rf, vecs[i].wbr);
      check_output($sformatf("vec%0d issue_ready", i), 32'(bus.issue_ready), 32'(vecs[i].e_ir));
      check_output($sformatf("vec%0d wb_valid", i), 32'(bus.wb_valid), 32'(vecs[i].e_wv));
      check_output($sformatf("vec%0d flags", i), 32'(flags), 32'(vecs[i].e_flags));
      check_output($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
      check_output($sformatf("vec%0d seq_error", i), 32'(seq_error), 32'd0);
      if (vecs[i].e_wv) begin
        check_output($sformatf("vec%0d wb_reg", i), 32'(bus.wb_reg), 32'(vecs[i].e_reg));
        check_output($sformatf("vec%0d wb_data", i), 32'(bus.wb_data), 32'(vecs[i].e_data));
      end
      advance();
    end

    // Wrong unit leaves the entry pending; the right unit then retires it.
    step(1'b1, 2'd1, 4'd5, 1'b1, 4'b0000, 8'h00, 4'h0, 1'b0);
    step(1'b0, 2'd0, 4'd0, 1'b0, 4'b0100, 8'h77, 4'hF, 1'b0);
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b0);
    check_output("err wrong unit seq_error", 32'(seq_error), 32'd1);
    check_output("err wrong unit wb_valid", 32'(bus.wb_valid), 32'd0);
    check_output("err wrong unit busy", 32'(busy), 32'd1);
    advance();
    step(1'b0, 2'd0, 4'd0, 1'b0, 4'b0010, 8'h5A, 4'b0100, 1'b1);
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b1);
    check_output("err recover wb_valid", 32'(bus.wb_valid), 32'd1);
    check_output("err recover wb_reg", 32'(bus.wb_reg), 32'd5);
    check_output("err recover wb_data", 32'(bus.wb_data), 32'h5A);
    advance();
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b1);
    check_output("err recover flags", 32'(flags), 32'b0100);
    check_output("err recover busy", 32'(busy), 32'd0);
    advance();
    step(1'b0, 2'd0, 4'd0, 1'b0, 4'b0011, 8'h99, 4'hF, 1'b1);
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b1);
    check_output("err double seq_error", 32'(seq_error), 32'd1);
    check_output("err double wb_valid", 32'(bus.wb_valid), 32'd0);
    check_output("err double busy", 32'(busy), 32'd0);
    advance();

    // Ten back-to-back ops wrap the pointers and must retire one per cycle.
    for (int c = 0; c < 12; c++) begin
      logic [NU-1:0] rm;
      rm = (c >= 1 && c <= 10) ? NU'(1 << ((c - 1) % 2)) : '0;
      apply_stimulus(c < 10, UW'(c % 2), RW'(c), 1'b0, rm, DW'(8'hA0 + c - 1), 4'hF, 1'b1);
      if (c >= 2) begin
        check_output($sformatf("wrap%0d wb_valid", c), 32'(bus.wb_valid), 32'd1);
        check_output($sformatf("wrap%0d wb_data", c), 32'(bus.wb_data), 32'(8'hA0 + c - 2));
      end
      check_model();
      advance();
    end
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b1);
    check_output("wrap flags held", 32'(flags), 32'b0100);
    check_output("wrap drained busy", 32'(busy), 32'd0);
    advance();

    // Reset with three ops in flight, two of them done, and the port stalled.
    step(1'b1, 2'd0, 4'd1, 1'b1, 4'b0000, 8'h00, 4'h0, 1'b0);
    step(1'b1, 2'd1, 4'd2, 1'b1, 4'b0001, 8'hC1, 4'hF, 1'b0);
    step(1'b1, 2'd2, 4'd3, 1'b1, 4'b0010, 8'hC2, 4'hF, 1'b0);
    rst_n = 1'b0;
    #1;
    check_output("midreset wb_valid", 32'(bus.wb_valid), 32'd0);
    check_output("midreset busy", 32'(busy), 32'd0);
    check_output("midreset flags", 32'(flags), 32'd0);
    check_output("midreset issue_ready", 32'(bus.issue_ready), 32'd1);
    check_output("midreset seq_error", 32'(seq_error), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) idle(1'b1);

    for (int i = 0; i < 400; i++) begin
      int k;
      int r;
      logic [NU-1:0] rm;
      k  = first_pending();
      r  = int'($urandom_range(0, 99));
      rm = '0;
      if (r < 3) rm = NU'($urandom_range(1, 15));
      else if (r < 70 && k >= 0) rm = NU'(1) << m_q[k].unit;
      step(1'($urandom), UW'($urandom), RW'($urandom), 1'($urandom),
           rm, DW'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
